fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 24, meaning instruction word width (opcode plus operand).
REQ-002 SHALL have parameter OPC_WIDTH, default 8, meaning opcode field width (bits WORD_WIDTH-1 down to 16).
REQ-003 SHALL have parameter PC_WIDTH, default 16, meaning program counter and ROM address width.
REQ-004 SHALL have port: clk  in  1  single system clock, all state on rising edge.
REQ-005 SHALL have port: rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have port: rom_addr  out  PC_WIDTH  address driven to the program ROM (combinational ROM, same-cycle data).
REQ-007 SHALL have port: rom_data  in  WORD_WIDTH  instruction word returned by the ROM.
REQ-008 SHALL have port: ir_valid  out  1  instruction register holds an instruction offered downstream.
REQ-009 SHALL have port: ir_ready  in  1  downstream accepts the offered instruction this cycle.
REQ-010 SHALL have port: ir_opcode  out  OPC_WIDTH  opcode field of the held instruction.
REQ-011 SHALL have port: ir_operand  out  16  operand field of the held instruction.
REQ-012 SHALL have port: ir_pc  out  PC_WIDTH  address the held instruction was fetched from.
REQ-013 SHALL have port: jmp_taken  in  1  redirect request from execute stage.
REQ-014 SHALL have port: jmp_target  in  PC_WIDTH  redirect address, sampled when jmp_taken=1.
REQ-015 SHALL have port: icount  out  16  count of issued instructions (see Configuration).

Function
REQ-016 SHALL implement FSM states FETCH and ISSUE; rom_addr SHALL equal pc in all states.
REQ-017 In FETCH, SHALL latch rom_data into the IR and pc into ir_pc at the clock edge, set ir_valid=1, and go to ISSUE.
REQ-018 In ISSUE, SHALL hold IR, ir_pc and ir_valid=1 stable while ir_ready=0 (stall, any length).
REQ-019 In ISSUE with ir_ready=1 (handshake), SHALL set pc <= pc+1, ir_valid <= 0 and go to FETCH; throughput is one instruction per 2 cycles.
REQ-020 pc increment SHALL wrap modulo 2^PC_WIDTH (0xFFFF -> 0x0000), no flag raised.
REQ-021 jmp_taken=1 in any state SHALL set pc <= jmp_target, ir_valid <= 0, state <= FETCH next cycle, discarding any held un-accepted instruction.
REQ-022 jmp_taken=1 coincident with a handshake SHALL count the instruction as issued, and jump SHALL override the pc+1 increment.
REQ-023 Handshake of an instruction whose opcode equals the shared RST opcode SHALL set pc <= 0 and go to FETCH (soft restart); jmp_taken in the same cycle SHALL take priority.
REQ-024 ir_ready while ir_valid=0 SHALL be ignored.

Reset
REQ-025 When rst=1 at a clock edge: pc=0, state=FETCH, ir_valid=0, ir_opcode=0, ir_operand=0, ir_pc=0, icount=0; rst SHALL override jmp_taken and handshake.
REQ-026 rst asserted mid-stall SHALL drop the held instruction; first fetch after release SHALL be from address 0.

Configuration
REQ-027 Macro FETCH_ICOUNT_EN: when defined, icount SHALL increment by 1 (wrapping at 0xFFFF) on every handshake, including the RST instruction; when undefined, icount SHALL be constant 0 and no counter register SHALL be built.

Verification
REQ-028 Reset, ROM mem[0]=NOP, mem[1]=LDI 0x5, ir_ready=1 -> ir_valid first high 1 cycle after reset release with ir_pc=0; next offered ir_pc=1, ir_operand=0x0005, 2 cycles apart.
REQ-029 Hold ir_ready=0 for 5 cycles while offering LDI 0x5 -> ir_valid, ir_opcode, ir_operand, ir_pc=1 unchanged all 5 cycles; pc advances only after ir_ready=1.
REQ-030 Pulse jmp_taken=1, jmp_target=0x0009 during a stall at ir_pc=10 -> held instruction dropped (ir_valid=0 next cycle), next offered ir_pc=0x0009 (INC).
REQ-031 Run to ROM address 11 (RST) with ir_ready=1 -> after its handshake next offered ir_pc=0; with FETCH_ICOUNT_EN defined icount=12 at that point, undefined icount=0.
REQ-032 Force pc to 0xFFFF via jmp_target=0xFFFF, accept -> next fetch rom_addr=0x0000.
REQ-033 Assert rst for 1 cycle during a stall at ir_pc=5 -> ir_valid=0, icount=0, next offered ir_pc=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM port, instruction-register handshake, redirect and issue count.
// The fetch unit is the master; the ROM/decode/execute side is the slave.
interface fetch_unit_if #(
   parameter int WORD_WIDTH = 24,
   parameter int OPC_WIDTH  = 8,
   parameter int PC_WIDTH   = 16
);
   logic [PC_WIDTH-1:0]   rom_addr;
   logic [WORD_WIDTH-1:0] rom_data;
   logic                  ir_valid;
   logic                  ir_ready;
   logic [OPC_WIDTH-1:0]  ir_opcode;
   logic [15:0]           ir_operand;
   logic [PC_WIDTH-1:0]   ir_pc;
   logic                  jmp_taken;
   logic [PC_WIDTH-1:0]   jmp_target;
   logic [15:0]           icount;

   modport master (
      output rom_addr, ir_valid, ir_opcode, ir_operand, ir_pc, icount,
      input  rom_data, ir_ready, jmp_taken, jmp_target
   );

   modport slave (
      input  rom_addr, ir_valid, ir_opcode, ir_operand, ir_pc, icount,
      output rom_data, ir_ready, jmp_taken, jmp_target
   );
endinterface

// File: rtl/fetch_unit.sv
// Two-state fetch/issue unit: one ROM read per FETCH, instruction held in ISSUE until accepted.
// Optional issue counter enabled by macro FETCH_ICOUNT_EN.
module fetch_unit #(
   parameter int                   WORD_WIDTH = 24,
   parameter int                   OPC_WIDTH  = 8,
   parameter int                   PC_WIDTH   = 16,
   parameter logic [OPC_WIDTH-1:0] RST_OPC    = '1
) (
   input  logic          clk,
   input  logic          rst,
   fetch_unit_if.master  bus
);
   localparam logic [0:0] S_FETCH = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [0:0]           r_state;
   logic [PC_WIDTH-1:0]  r_pc;
   logic                 r_ir_valid;
   logic [OPC_WIDTH-1:0] r_opcode;
   logic [15:0]          r_operand;
   logic [PC_WIDTH-1:0]  r_ir_pc;
   logic                 w_hs;

   // ir_ready is only meaningful while an instruction is held
   assign w_hs = (r_state == S_ISSUE) && bus.ir_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_FETCH;
         r_pc       <= '0;
         r_ir_valid <= 1'b0;
         r_opcode   <= '0;
         r_operand  <= '0;
         r_ir_pc    <= '0;
      end else if (bus.jmp_taken) begin
         r_state    <= S_FETCH;
         r_pc       <= bus.jmp_target;
         r_ir_valid <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: begin
               r_opcode   <= bus.rom_data[WORD_WIDTH-1:16];
               r_operand  <= bus.rom_data[15:0];
               r_ir_pc    <= r_pc;
               r_ir_valid <= 1'b1;
               r_state    <= S_ISSUE;
            end
            default: begin
               if (w_hs) begin
                  r_pc       <= (r_opcode == RST_OPC) ? '0 : r_pc + 1'b1;
                  r_ir_valid <= 1'b0;
                  r_state    <= S_FETCH;
               end
            end
         endcase
      end
   end

   assign bus.rom_addr   = r_pc;
   assign bus.ir_valid   = r_ir_valid;
   assign bus.ir_opcode  = r_opcode;
   assign bus.ir_operand = r_operand;
   assign bus.ir_pc      = r_ir_pc;

`ifdef FETCH_ICOUNT_EN
   logic [15:0] r_icount;

   // A handshake counts even when a same-cycle jump discards the fall-through
   always_ff @(posedge clk) begin
      if (rst)       r_icount <= '0;
      else if (w_hs) r_icount <= r_icount + 16'd1;
   end

   assign bus.icount = r_icount;
`else
   assign bus.icount = '0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_fetch_unit;
   localparam logic [7:0] NOP = 8'h00;
   localparam logic [7:0] LDI = 8'h10;
   localparam logic [7:0] INC = 8'h20;
   localparam logic [7:0] RST = 8'hFF;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [23:0] rom [0:65535];

   fetch_unit_if #(.WORD_WIDTH(24), .OPC_WIDTH(8), .PC_WIDTH(16)) bus ();

   fetch_unit #(.WORD_WIDTH(24), .OPC_WIDTH(8), .PC_WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   assign bus.rom_data = rom[bus.rom_addr];

   always #5 clk = ~clk;

   // Reference model: "is an instruction held", what it is, where fetch points next
   logic        m_held;
   logic [15:0] m_pc, m_ir_pc, m_cnt;
   logic [23:0] m_word;

   task automatic tick();
      logic        hs, held;
      logic [15:0] pc, ir_pc, cnt;
      logic [23:0] word;
      hs = m_held && bus.ir_ready;
      held = m_held; pc = m_pc; ir_pc = m_ir_pc; cnt = m_cnt; word = m_word;
      if (rst) begin
         held = 1'b0; pc = 16'h0; ir_pc = 16'h0; word = 24'h0; cnt = 16'h0;
      end else begin
`ifdef FETCH_ICOUNT_EN
         if (hs) cnt = cnt + 16'd1;
`endif
         if (bus.jmp_taken) begin
            pc = bus.jmp_target; held = 1'b0;
         end else if (!m_held) begin
            word = rom[m_pc]; ir_pc = m_pc; held = 1'b1;
         end else if (hs) begin
            pc = (m_word[23:16] == RST) ? 16'h0 : m_pc + 16'd1;
            held = 1'b0;
         end
      end
      @(posedge clk); #1;
      m_held = held; m_pc = pc; m_ir_pc = ir_pc; m_cnt = cnt; m_word = word;
   endtask

   // Advance with ready=1 until the instruction at addr is offered
   task automatic run_to(input logic [15:0] addr, output bit ok);
      ok = 1'b0;
      bus.ir_ready = 1'b1;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (bus.ir_valid && bus.ir_pc == addr) ok = 1'b1;
         else tick();
      end
   endtask

   task automatic test_reset();
      bus.ir_ready = 1'b0; bus.jmp_taken = 1'b0; bus.jmp_target = 16'h0;
      rst = 1'b1;
      m_held = 1'b0; m_pc = 16'hx; m_ir_pc = 16'hx; m_cnt = 16'hx; m_word = 24'hx;
      tick(); tick();
      n_tests++;
      if (bus.ir_valid !== 1'b0 || bus.ir_opcode !== 8'h0 || bus.ir_operand !== 16'h0 ||
          bus.ir_pc !== 16'h0 || bus.icount !== 16'h0 || bus.rom_addr !== 16'h0) begin
         n_fail++;
         $display("FAIL reset: valid=%b opc=%h opr=%h ir_pc=%h icount=%h rom_addr=%h, want all 0",
                  bus.ir_valid, bus.ir_opcode, bus.ir_operand, bus.ir_pc, bus.icount, bus.rom_addr);
      end
   endtask

   task automatic test_first_fetch();
      bus.ir_ready = 1'b1;
      rst = 1'b0;
      tick();
      n_tests++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'h0 || bus.ir_opcode !== NOP) begin
         n_fail++;
         $display("FAIL first_fetch: valid=%b ir_pc=%h opc=%h, want 1/0000/%h",
                  bus.ir_valid, bus.ir_pc, bus.ir_opcode, NOP);
      end
      tick();
      n_tests++;
      if (bus.ir_valid !== 1'b0 || bus.rom_addr !== 16'h1) begin
         n_fail++;
         $display("FAIL first_accept: valid=%b rom_addr=%h, want 0/0001", bus.ir_valid, bus.rom_addr);
      end
      tick();
      n_tests++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'h1 || bus.ir_opcode !== LDI ||
          bus.ir_operand !== 16'h0005) begin
         n_fail++;
         $display("FAIL second_fetch: valid=%b ir_pc=%h opc=%h opr=%h, want 1/0001/%h/0005",
                  bus.ir_valid, bus.ir_pc, bus.ir_opcode, bus.ir_operand, LDI);
      end
      bus.ir_ready = 1'b0;
   endtask

   task automatic test_stall();
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'h1 || bus.ir_opcode !== LDI ||
             bus.ir_operand !== 16'h0005 || bus.rom_addr !== 16'h1) bad++;
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL stall_hold: %0d of 5 cycles changed, want 0 (last ir_pc=%h rom_addr=%h)",
                  bad, bus.ir_pc, bus.rom_addr);
      end
      bus.ir_ready = 1'b1;
      tick();
      n_tests++;
      if (bus.ir_valid !== 1'b0 || bus.rom_addr !== 16'h2) begin
         n_fail++;
         $display("FAIL stall_release: valid=%b rom_addr=%h, want 0/0002", bus.ir_valid, bus.rom_addr);
      end
   endtask

   task automatic test_jump();
      bit ok;
      run_to(16'd10, ok);
      bus.ir_ready = 1'b0;
      tick(); tick();
      n_tests++;
      if (!ok || bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'd10) begin
         n_fail++;
         $display("FAIL jump_setup: reached=%0d valid=%b ir_pc=%h, want 1/1/000a", ok, bus.ir_valid, bus.ir_pc);
      end
      bus.jmp_taken = 1'b1; bus.jmp_target = 16'h0009;
      tick();
      bus.jmp_taken = 1'b0;
      n_tests++;
      if (bus.ir_valid !== 1'b0 || bus.rom_addr !== 16'h0009) begin
         n_fail++;
         $display("FAIL jump_drop: valid=%b rom_addr=%h, want 0/0009", bus.ir_valid, bus.rom_addr);
      end
      tick();
      n_tests++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'h0009 || bus.ir_opcode !== INC) begin
         n_fail++;
         $display("FAIL jump_target: valid=%b ir_pc=%h opc=%h, want 1/0009/%h",
                  bus.ir_valid, bus.ir_pc, bus.ir_opcode, INC);
      end
   endtask

   task automatic test_rst_opcode();
      bit ok;
      logic [15:0] exp_cnt;
`ifdef FETCH_ICOUNT_EN
      exp_cnt = 16'd12;
`else
      exp_cnt = 16'd0;
`endif
      rst = 1'b1; tick(); rst = 1'b0;
      run_to(16'd11, ok);
      n_tests++;
      if (!ok || bus.ir_opcode !== RST) begin
         n_fail++;
         $display("FAIL rst_op_reach: reached=%0d opc=%h, want 1/%h", ok, bus.ir_opcode, RST);
      end
      tick();
      n_tests++;
      if (bus.rom_addr !== 16'h0 || bus.icount !== exp_cnt) begin
         n_fail++;
         $display("FAIL rst_op_restart: rom_addr=%h icount=%0d, want 0000/%0d", bus.rom_addr, bus.icount, exp_cnt);
      end
      tick();
      n_tests++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_op_refetch: valid=%b ir_pc=%h, want 1/0000", bus.ir_valid, bus.ir_pc);
      end
   endtask

   task automatic test_wrap();
      bus.ir_ready = 1'b0;
      bus.jmp_taken = 1'b1; bus.jmp_target = 16'hFFFF;
      tick();
      bus.jmp_taken = 1'b0;
      tick();
      n_tests++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL wrap_fetch: valid=%b ir_pc=%h, want 1/ffff", bus.ir_valid, bus.ir_pc);
      end
      bus.ir_ready = 1'b1;
      tick();
      n_tests++;
      if (bus.rom_addr !== 16'h0000 || bus.ir_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_pc: rom_addr=%h valid=%b, want 0000/0", bus.rom_addr, bus.ir_valid);
      end
   endtask

   task automatic test_mid_rst();
      bus.ir_ready = 1'b0;
      bus.jmp_taken = 1'b1; bus.jmp_target = 16'h0005;
      tick();
      bus.jmp_taken = 1'b0;
      tick(); tick();
      n_tests++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'h0005) begin
         n_fail++;
         $display("FAIL mid_rst_setup: valid=%b ir_pc=%h, want 1/0005", bus.ir_valid, bus.ir_pc);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_tests++;
      if (bus.ir_valid !== 1'b0 || bus.icount !== 16'h0 || bus.rom_addr !== 16'h0) begin
         n_fail++;
         $display("FAIL mid_rst_clear: valid=%b icount=%0d rom_addr=%h, want 0/0/0000",
                  bus.ir_valid, bus.icount, bus.rom_addr);
      end
      tick();
      n_tests++;
      if (bus.ir_valid !== 1'b1 || bus.ir_pc !== 16'h0) begin
         n_fail++;
         $display("FAIL mid_rst_refetch: valid=%b ir_pc=%h, want 1/0000", bus.ir_valid, bus.ir_pc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         bus.ir_ready  = ($urandom_range(0, 99) < 55);
         bus.jmp_taken = ($urandom_range(0, 99) < 8);
         bus.jmp_target = ($urandom_range(0, 9) == 0) ? 16'hFFFE : 16'($urandom_range(0, 63));
         rst = ($urandom_range(0, 99) < 2);
         tick();
         n_tests++;
         if (bus.rom_addr !== m_pc || bus.ir_valid !== m_held || bus.ir_pc !== m_ir_pc ||
             bus.ir_opcode !== m_word[23:16] || bus.ir_operand !== m_word[15:0] || bus.icount !== m_cnt) begin
            n_fail++;
            $display("FAIL random[%0d]: addr=%h v=%b pc=%h opc=%h opr=%h cnt=%0d, want %h/%b/%h/%h/%h/%0d",
                     i, bus.rom_addr, bus.ir_valid, bus.ir_pc, bus.ir_opcode, bus.ir_operand, bus.icount,
                     m_pc, m_held, m_ir_pc, m_word[23:16], m_word[15:0], m_cnt);
         end
      end
      rst = 1'b0; bus.jmp_taken = 1'b0;
   endtask

   initial begin
      for (int a = 0; a < 65536; a++) rom[a] = {NOP, 16'(a ^ 16'h5A5A)};
      rom[0] = {NOP, 16'h0000};
      rom[1] = {LDI, 16'h0005};
      for (int a = 2; a < 9; a++) rom[a] = {NOP, 16'(a)};
      rom[9]  = {INC, 16'h0000};
      rom[10] = {LDI, 16'h000A};
      rom[11] = {RST, 16'h0000};
      for (int a = 12; a < 64; a++) begin
         case ($urandom_range(0, 3))
            0:       rom[a] = {NOP, 16'($urandom)};
            1:       rom[a] = {LDI, 16'($urandom)};
            2:       rom[a] = {INC, 16'($urandom)};
            default: rom[a] = {RST, 16'($urandom)};
         endcase
      end
      test_reset();
      test_first_fetch();
      test_stall();
      test_jump();
      test_rst_opcode();
      test_wrap();
      test_mid_rst();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
